and3_stim_gen: RTL and testbench
================================

AND3_STIM_GEN -- requirements
Module: and3_stim_gen

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10, giving the cycles each input vector is held (legal range 1..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  in  1  one-cycle request to run one full sweep.
REQ-005 SHALL have ports x, y, w  out  1 each  driven onto the 3-input AND gate inputs.
REQ-006 SHALL have port z  in  1  AND gate output, fed back for checking.
REQ-007 SHALL have port busy  out  1  high while a sweep is in progress.
REQ-008 SHALL have port done  out  1  one-cycle pulse at sweep end.
REQ-009 SHALL have port vec_idx  out  3  index (0..7) of the vector currently driven.
REQ-010 SHALL have port err_cnt  out  8  count of mismatching samples in the current or last sweep.
REQ-011 SHALL have port pass  out  1  high when the last completed sweep had err_cnt==0.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, DONE: IDLE->DRIVE on start; DRIVE->DONE after the final hold of vector 7; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL drive {x,y,w} in Gray order, w as LSB: 000,001,011,010,110,111,101,100 for vec_idx 0..7.
REQ-014 SHALL present vector 0 from the cycle after start is sampled, with busy=1 from that same cycle.
REQ-015 SHALL hold each vector exactly HOLD_CYCLES cycles, counting 0..HOLD_CYCLES-1, then advance vec_idx.
REQ-016 SHALL sample z on the terminal hold cycle of each vector and compare it with x&y&w of that vector.
REQ-017 SHALL increment err_cnt on each mismatch, saturating at 255.
REQ-018 SHALL clear err_cnt and deassert pass on the cycle start is accepted.
REQ-019 SHALL assert done for one cycle in DONE, busy=0 in DONE, and update pass there; pass holds until the next accepted start.
REQ-020 SHALL give a sweep of exactly 8*HOLD_CYCLES busy cycles, with done at start cycle + 8*HOLD_CYCLES + 1.
REQ-021 SHALL ignore start while in DRIVE or DONE, with no restart and no counter disturbance.
REQ-022 SHALL drive x=y=w=0 and vec_idx=0 in IDLE and DONE.

Reset
REQ-023 SHALL on rst, at any point including mid-sweep, enter IDLE next edge with x=y=w=0, vec_idx=0, hold counter=0, busy=0, done=0, err_cnt=0, pass=0.
REQ-024 SHALL give rst priority over start when both are high in the same cycle.

Configuration
REQ-025 SHALL compile the checker only when AND3_SELF_CHECK_EN is defined, implementing REQ-016..REQ-018.
REQ-026 SHALL without AND3_SELF_CHECK_EN tie err_cnt to 0 and pass to 1, leave z unused, and keep sequencing, timing, busy and done identical.

Structure
REQ-027 SHALL place the state enum, VEC_COUNT=8 and the 8-entry Gray vector table constant in package and3_stim_pkg.
REQ-028 SHALL implement the hold counter and its terminal-count flag as sub-module and3_hold_timer (parameter HOLD_CYCLES; ports clk, rst, clr, en, tc).

Verification (HOLD_CYCLES=10 unless stated)
REQ-029 SHALL cover: rst, start pulse with a real AND gate on z -> vectors in Gray order, 10 cycles each, done 81 cycles after start, err_cnt=0, pass=1.
REQ-030 SHALL cover: z stuck at 0 -> err_cnt=1 (vector 111 only), pass=0; z stuck at 1 -> err_cnt=7, pass=0.
REQ-031 SHALL cover: start re-pulsed at vec_idx=3 and on the done cycle -> both ignored, sweep length unchanged; a later start clears err_cnt.
REQ-032 SHALL cover: rst at vec_idx=4 mid-hold -> next cycle busy=0, xyw=000, vec_idx=0, err_cnt=0; rst+start together -> stays IDLE.
REQ-033 SHALL cover: HOLD_CYCLES=1 -> 8 busy cycles, one vector per cycle; build without AND3_SELF_CHECK_EN -> pass=1, err_cnt=0 even with z stuck at 0.

Source files
------------

// File: rtl/and3_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : and3_stim_pkg
// Description : Shared types and constants for the 3-input AND stimulus
//               generator: FSM state encoding and the Gray-order vector table.
// Revision    : 1.0 - initial release
// ============================================================================
package and3_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int VEC_COUNT = 8;

    // Entry i is {x,y,w} for vec_idx i; one input changes per step.
    localparam logic [VEC_COUNT-1:0][2:0] GRAY_TABLE = {
        3'b100, 3'b101, 3'b111, 3'b110,
        3'b010, 3'b011, 3'b001, 3'b000
    };

    function automatic logic [2:0] gray_vec(input logic [2:0] idx);
        return GRAY_TABLE[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/and3_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : and3_hold_timer
// Description : Per-vector hold counter, counts 0..HOLD_CYCLES-1 while enabled
//               and flags the terminal cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module and3_hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] C_TERM = 8'(HOLD_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tc = en && (cnt_q == C_TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = tc ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/and3_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : and3_stim_gen
// Description : Sweeps a 3-input AND gate through all 8 input vectors in Gray
//               order; optional checker enabled by AND3_SELF_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module and3_stim_gen
    import and3_stim_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x,
    output logic       y,
    output logic       w,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic [2:0] vec_idx,
    output logic [7:0] err_cnt,
    output logic       pass
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] vec_q;
    logic [2:0] vec_d;
    logic       w_start_acc;
    logic       w_last;
    logic       w_tc;
    logic       w_drive;

    assign w_drive = (state_q == ST_DRIVE);

    and3_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_start_acc),
        .en  (w_drive),
        .tc  (w_tc)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        w_start_acc = 1'b0;
        w_last      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    vec_d       = 3'd0;
                    w_start_acc = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_tc) begin
                    if (vec_q == 3'(VEC_COUNT - 1)) begin
                        state_d = ST_DONE;
                        vec_d   = 3'd0;
                        w_last  = 1'b1;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    assign {x, y, w} = w_drive ? gray_vec(vec_q) : 3'b000;
    assign busy      = w_drive;
    assign done      = (state_q == ST_DONE);
    assign vec_idx   = vec_q;

`ifdef AND3_SELF_CHECK_EN
    logic [7:0] err_q;
    logic [7:0] err_d;
    logic       pass_q;
    logic       pass_d;
    logic       w_mismatch;

    assign w_mismatch = w_tc && (z != (x & y & w));

    // pass is resolved on entry to DONE so it is valid alongside done.
    always_comb begin
        err_d  = err_q;
        pass_d = pass_q;
        if (w_start_acc) begin
            err_d  = 8'd0;
            pass_d = 1'b0;
        end else begin
            if (w_mismatch && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
            if (w_last) begin
                pass_d = (err_d == 8'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 8'd0;
            pass_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    assign err_cnt = err_q;
    assign pass    = pass_q;
`else
    logic [1:0] w_unused_sig;
    assign w_unused_sig = {z, w_last};
    assign err_cnt      = 8'd0;
    assign pass         = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_and3_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_and3_stim_gen
// Description : Directed self-checking bench for and3_stim_gen (HOLD 10 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and3_stim_gen;

`ifdef AND3_SELF_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [1:0] zmode = 2'd0;   // 0: real AND, 1: stuck 0, 2: stuck 1

    logic       x, y, w, z, busy, done, pass;
    logic [2:0] vec_idx;
    logic [7:0] err_cnt;
    logic       x1, y1, w1, z1, busy1, done1, pass1;
    logic [2:0] vec_idx1;
    logic [7:0] err_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_vec [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                3'b110, 3'b111, 3'b101, 3'b100};

    always #5 clk = ~clk;

    assign z  = (zmode == 2'd0) ? (x & y & w) : (zmode == 2'd2);
    assign z1 = x1 & y1 & w1;

    and3_stim_gen #(.HOLD_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x(x), .y(y), .w(w), .z(z),
        .busy(busy), .done(done), .vec_idx(vec_idx),
        .err_cnt(err_cnt), .pass(pass)
    );

    and3_stim_gen #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .x(x1), .y(y1), .w(w1), .z(z1),
        .busy(busy1), .done(done1), .vec_idx(vec_idx1),
        .err_cnt(err_cnt1), .pass(pass1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with dut idle; covers the whole sweep plus the cycle after done.
    task automatic sweep(input logic [7:0] exp_err, input logic exp_pass, input bit poke);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_err", 32'(err_cnt), 32'(0));
        chk("clr_pass", 32'(pass), 32'(CHK ? 1'b0 : 1'b1));
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < 10; h++) begin
                chk("busy", 32'(busy), 32'(1));
                chk("vec_idx", 32'(vec_idx), 32'(v));
                chk("xyw", 32'({x, y, w}), 32'(exp_vec[v]));
                chk("done_low", 32'(done), 32'(0));
                start = (poke && v == 3 && h == 4);
                @(negedge clk);
            end
        end
        start = poke;
        chk("done", 32'(done), 32'(1));
        chk("busy_done", 32'(busy), 32'(0));
        chk("xyw_done", 32'({x, y, w}), 32'(0));
        chk("vec_done", 32'(vec_idx), 32'(0));
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("pass", 32'(pass), 32'(exp_pass));
        @(negedge clk);
        start = 1'b0;
        chk("idle_done", 32'(done), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("pass_hold", 32'(pass), 32'(exp_pass));
        @(negedge clk);
        chk("no_restart", 32'(busy), 32'(0));
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_vec", 32'(vec_idx), 32'(0));
        chk("rst_xyw", 32'({x, y, w}), 32'(0));
        chk("rst_err", 32'(err_cnt), 32'(0));
        chk("rst_pass", 32'(pass), 32'(CHK ? 1'b0 : 1'b1));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy0", 32'(busy), 32'(0));

        // Real AND gate: clean sweep
        zmode = 2'd0;
        sweep(8'd0, 1'b1, 1'b0);

        // z stuck at 0: only vector 111 mismatches
        zmode = 2'd1;
        sweep(CHK ? 8'd1 : 8'd0, CHK ? 1'b0 : 1'b1, 1'b0);

        // z stuck at 1: seven mismatches
        zmode = 2'd2;
        sweep(CHK ? 8'd7 : 8'd0, CHK ? 1'b0 : 1'b1, 1'b0);

        // Restart attempts mid-sweep and on done are ignored; start clears err_cnt
        zmode = 2'd0;
        sweep(8'd0, 1'b1, 1'b1);

        // Reset mid-hold of vector 4 with errors accumulated
        zmode = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (43) @(negedge clk);
        chk("pre_rst_vec", 32'(vec_idx), 32'(4));
        chk("pre_rst_err", 32'(err_cnt), 32'(CHK ? 4 : 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_xyw", 32'({x, y, w}), 32'(0));
        chk("mid_rst_vec", 32'(vec_idx), 32'(0));
        chk("mid_rst_err", 32'(err_cnt), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));

        // rst and start together: reset wins
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'(0));
        @(negedge clk);
        chk("rst_start_idle", 32'(busy), 32'(0));
        chk("rst_start_vec", 32'(vec_idx), 32'(0));

        // HOLD_CYCLES=1 instance: one vector per cycle
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int v = 0; v < 8; v++) begin
            chk("h1_busy", 32'(busy1), 32'(1));
            chk("h1_vec", 32'(vec_idx1), 32'(v));
            chk("h1_xyw", 32'({x1, y1, w1}), 32'(exp_vec[v]));
            @(negedge clk);
        end
        chk("h1_done", 32'(done1), 32'(1));
        chk("h1_busy_done", 32'(busy1), 32'(0));
        chk("h1_err", 32'(err_cnt1), 32'(0));
        chk("h1_pass", 32'(pass1), 32'(1));
        @(negedge clk);
        chk("h1_idle", 32'(done1), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
